// File: rtl/conv_stride_decoder_pkg.sv
// Shared types for the stride-instruction decoder: FSM states, the latched
// instruction record and the BRAM read latency the MAC tags are aligned to.
package conv_pkg;

   localparam int unsigned FRAM_ADDR_WIDTH = 12;
   localparam int unsigned KRAM_ADDR_WIDTH = 12;
   localparam int unsigned DIM_WIDTH       = 32;
   localparam int unsigned BRAM_RD_LATENCY = 1;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StBias,
      StIssue,
      StDrain
   } state_e;

   typedef struct packed {
      logic [FRAM_ADDR_WIDTH-1:0] feature_base;
      logic [KRAM_ADDR_WIDTH-1:0] kernel_base;
      logic [DIM_WIDTH-1:0]       chin;
      logic [DIM_WIDTH-1:0]       chout;
      logic [DIM_WIDTH-1:0]       width;
      logic [DIM_WIDTH-1:0]       height;
      logic [7:0]                 kh;
      logic [7:0]                 kw;
      logic                       has_bias;
      logic                       has_relu;
      logic [FRAM_ADDR_WIDTH-1:0] wb_base;
      logic [DIM_WIDTH-1:0]       wb_ch_offset;
   } stride_inst_t;

endpackage

// File: rtl/conv_stride_decoder_addr_walker.sv
// Feature-address walker: nested kw/kh/ci counters producing one feature word
// address per step; a full channel walk reloads the pointers to fbase.
module conv_addr_walker #(
   parameter int unsigned FADDR_W = 12,
   parameter int unsigned DIM_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               step,
   input  logic [FADDR_W-1:0] fbase,
   input  logic [FADDR_W-1:0] ch_off,
   input  logic [DIM_W-1:0]   width,
   input  logic [DIM_W-1:0]   chin,
   input  logic [7:0]         kh,
   input  logic [7:0]         kw,
   output logic [FADDR_W-1:0] addr,
   output logic               at_start,
   output logic               chan_wrap
);

   logic [7:0]         kw_cnt_q, kw_cnt_d;
   logic [7:0]         kh_cnt_q, kh_cnt_d;
   logic [DIM_W-1:0]   ci_cnt_q, ci_cnt_d;
   logic [FADDR_W-1:0] col_q, col_d;
   logic [FADDR_W-1:0] row_q, row_d;
   logic [FADDR_W-1:0] ch_q, ch_d;
   logic [FADDR_W-1:0] width_f;
   logic               kw_wrap, kh_wrap;

   assign width_f   = FADDR_W'(width);
   assign kw_wrap   = (kw_cnt_q == kw - 8'd1);
   assign kh_wrap   = kw_wrap && (kh_cnt_q == kh - 8'd1);
   assign chan_wrap = kh_wrap && (ci_cnt_q == chin - DIM_W'(1));
   assign at_start  = (kw_cnt_q == 8'd0) && (kh_cnt_q == 8'd0) && (ci_cnt_q == '0);
   assign addr      = col_q;

   always_comb begin
      kw_cnt_d = kw_cnt_q;
      kh_cnt_d = kh_cnt_q;
      ci_cnt_d = ci_cnt_q;
      col_d    = col_q;
      row_d    = row_q;
      ch_d     = ch_q;
      if (load) begin
         kw_cnt_d = '0;
         kh_cnt_d = '0;
         ci_cnt_d = '0;
         col_d    = fbase;
         row_d    = fbase;
         ch_d     = fbase;
      end else if (step) begin
         if (!kw_wrap) begin
            kw_cnt_d = kw_cnt_q + 8'd1;
            col_d    = col_q + FADDR_W'(1);
         end else begin
            kw_cnt_d = '0;
            if (!kh_wrap) begin
               kh_cnt_d = kh_cnt_q + 8'd1;
               row_d    = row_q + width_f;
               col_d    = row_q + width_f;
            end else begin
               kh_cnt_d = '0;
               if (!chan_wrap) begin
                  ci_cnt_d = ci_cnt_q + DIM_W'(1);
                  ch_d     = ch_q + ch_off;
                  row_d    = ch_q + ch_off;
                  col_d    = ch_q + ch_off;
               end else begin
                  // Output channel finished: next channel re-reads the same window.
                  ci_cnt_d = '0;
                  ch_d     = fbase;
                  row_d    = fbase;
                  col_d    = fbase;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         kw_cnt_q <= '0;
         kh_cnt_q <= '0;
         ci_cnt_q <= '0;
         col_q    <= '0;
         row_q    <= '0;
         ch_q     <= '0;
      end else begin
         kw_cnt_q <= kw_cnt_d;
         kh_cnt_q <= kh_cnt_d;
         ci_cnt_q <= ci_cnt_d;
         col_q    <= col_d;
         row_q    <= row_d;
         ch_q     <= ch_d;
      end
   end

endmodule

// File: rtl/conv_stride_decoder.sv
// Stride-instruction consumer: expands each instruction into feature/kernel BRAM
// reads with MAC tags aligned to read data, and one writeback address per channel.
module conv_stride_decoder
   import conv_pkg::*;
#(
   parameter int unsigned FADDR_W = FRAM_ADDR_WIDTH,
   parameter int unsigned KADDR_W = KRAM_ADDR_WIDTH,
   parameter int unsigned DATA_W  = DIM_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FADDR_W-1:0] stride_feature_baseaddr,
   input  logic [KADDR_W-1:0] stride_kernel_baseaddr,
   input  logic [DATA_W-1:0]  stride_feature_chin,
   input  logic [DATA_W-1:0]  stride_feature_chout,
   input  logic [DATA_W-1:0]  stride_feature_width,
   input  logic [DATA_W-1:0]  stride_feature_height,
   input  logic [7:0]         stride_kernel_sizeh,
   input  logic [7:0]         stride_kernel_sizew,
   input  logic               stride_has_bias,
   input  logic               stride_has_relu,
   input  logic [FADDR_W-1:0] stride_wb_baseaddr,
   input  logic [DATA_W-1:0]  stride_wb_ch_offset,
   input  logic               inst_valid,
   input  logic               tlast,
   output logic               decoder_ready,
   output logic               fram_rd_en,
   output logic [FADDR_W-1:0] fram_rd_addr,
   output logic               kram_rd_en,
   output logic [KADDR_W-1:0] kram_rd_addr,
   output logic               mac_valid,
   output logic               mac_first,
   output logic               mac_bias,
   output logic               mac_last,
   output logic               mac_relu,
   output logic [FADDR_W-1:0] wb_addr,
   output logic               layer_done
);

   localparam int unsigned TagW = 5 + FADDR_W;

   state_e              state_q, state_d;
   stride_inst_t        inst_q, inst_d;
   logic                tlast_q;
   logic [FADDR_W-1:0]  ch_off_q;
   logic [FADDR_W-1:0]  wb_ptr_q;
   logic [KADDR_W-1:0]  kaddr_q;
   logic [DIM_WIDTH-1:0] co_cnt_q;
   logic                layer_done_q;

   logic                accept, dims_zero, co_last;
   logic                walk_start, chan_wrap;
   logic [FADDR_W-1:0]  walk_addr;
   logic                tag_first, tag_last;
   logic [TagW-1:0]     tag_d;
   logic [TagW-1:0]     tag_pipe_q [BRAM_RD_LATENCY];

   assign accept    = inst_valid && (state_q == StIdle);
   assign dims_zero = (inst_q.chin == '0) || (inst_q.chout == '0) ||
                      (inst_q.kh == 8'd0) || (inst_q.kw == 8'd0);
   assign co_last   = (co_cnt_q == inst_q.chout - DIM_WIDTH'(1));

   always_comb begin
      inst_d              = '0;
      inst_d.feature_base = FRAM_ADDR_WIDTH'(stride_feature_baseaddr);
      inst_d.kernel_base  = KRAM_ADDR_WIDTH'(stride_kernel_baseaddr);
      inst_d.chin         = DIM_WIDTH'(stride_feature_chin);
      inst_d.chout        = DIM_WIDTH'(stride_feature_chout);
      inst_d.width        = DIM_WIDTH'(stride_feature_width);
      inst_d.height       = DIM_WIDTH'(stride_feature_height);
      inst_d.kh           = stride_kernel_sizeh;
      inst_d.kw           = stride_kernel_sizew;
      inst_d.has_bias     = stride_has_bias;
      inst_d.has_relu     = stride_has_relu;
      inst_d.wb_base      = FRAM_ADDR_WIDTH'(stride_wb_baseaddr);
      inst_d.wb_ch_offset = DIM_WIDTH'(stride_wb_ch_offset);
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (inst_valid) state_d = StSetup;
         StSetup: begin
            if (dims_zero)            state_d = StIdle;
            else if (inst_q.has_bias) state_d = StBias;
            else                      state_d = StIssue;
         end
         StBias:  state_d = StIssue;
         StIssue: if (chan_wrap) state_d = StDrain;
         StDrain: begin
            if (co_last)              state_d = StIdle;
            else if (inst_q.has_bias) state_d = StBias;
            else                      state_d = StIssue;
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM: outputs and read-side tags
   always_comb begin
      decoder_ready = (state_q == StIdle);
      fram_rd_en    = (state_q == StIssue);
      kram_rd_en    = (state_q == StIssue) || (state_q == StBias);
      fram_rd_addr  = fram_rd_en ? walk_addr : '0;
      kram_rd_addr  = kram_rd_en ? kaddr_q : '0;
      tag_first     = (state_q == StBias) ||
                      ((state_q == StIssue) && !inst_q.has_bias && walk_start);
      tag_last      = (state_q == StIssue) && chan_wrap;
      tag_d         = {kram_rd_en, tag_first, (state_q == StBias), tag_last,
                       tag_last && inst_q.has_relu, tag_last ? wb_ptr_q : '0};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inst_q       <= '0;
         tlast_q      <= 1'b0;
         ch_off_q     <= '0;
         wb_ptr_q     <= '0;
         kaddr_q      <= '0;
         co_cnt_q     <= '0;
         layer_done_q <= 1'b0;
      end else begin
         layer_done_q <= tlast_q && (((state_q == StSetup) && dims_zero) ||
                                     ((state_q == StDrain) && co_last));
         if (accept) begin
            inst_q  <= inst_d;
            tlast_q <= tlast;
         end
         // Working pointers load one cycle after accept; no read happens before then.
         if (state_q == StSetup) begin
            ch_off_q <= FADDR_W'(inst_q.width * inst_q.height);
            wb_ptr_q <= FADDR_W'(inst_q.wb_base);
            kaddr_q  <= KADDR_W'(inst_q.kernel_base);
            co_cnt_q <= '0;
         end else begin
            if (kram_rd_en) kaddr_q <= kaddr_q + KADDR_W'(1);
            if (state_q == StDrain) begin
               wb_ptr_q <= wb_ptr_q + FADDR_W'(inst_q.wb_ch_offset);
               co_cnt_q <= co_cnt_q + DIM_WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BRAM_RD_LATENCY; i++) tag_pipe_q[i] <= '0;
      end else begin
         tag_pipe_q[0] <= tag_d;
         for (int i = 1; i < BRAM_RD_LATENCY; i++) tag_pipe_q[i] <= tag_pipe_q[i-1];
      end
   end

   assign {mac_valid, mac_first, mac_bias, mac_last, mac_relu, wb_addr} =
      tag_pipe_q[BRAM_RD_LATENCY-1];
   assign layer_done = layer_done_q;

   conv_addr_walker #(
      .FADDR_W (FADDR_W),
      .DIM_W   (DIM_WIDTH)
   ) u_walker (
      .clk       (clk),
      .rst       (rst),
      .load      (state_q == StSetup),
      .step      (fram_rd_en),
      .fbase     (FADDR_W'(inst_q.feature_base)),
      .ch_off    (ch_off_q),
      .width     (inst_q.width),
      .chin      (inst_q.chin),
      .kh        (inst_q.kh),
      .kw        (inst_q.kw),
      .addr      (walk_addr),
      .at_start  (walk_start),
      .chan_wrap (chan_wrap)
   );

endmodule

// File: tb/tb_conv_stride_decoder.sv
// Self-checking bench: builds a cycle-by-cycle expected trace from nested-loop
// arithmetic over each instruction and compares every DUT output per cycle.
module tb_conv_stride_decoder;

   localparam int unsigned FW = 12;
   localparam int unsigned KW = 12;
   localparam int unsigned DW = 32;
   localparam int unsigned FMASK = (1 << FW) - 1;
   localparam int unsigned KMASK = (1 << KW) - 1;

   typedef struct {
      int unsigned fbase, kbase, chin, chout, width, height, kh, kw, wb_base, wb_off;
      bit          bias, relu, tlast;
   } inst_t;

   typedef struct {
      bit          fen, ken, first, bias, last, relu, ready, done;
      int unsigned fa, ka, wb;
   } cyc_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [FW-1:0] stride_feature_baseaddr;
   logic [KW-1:0] stride_kernel_baseaddr;
   logic [DW-1:0] stride_feature_chin, stride_feature_chout;
   logic [DW-1:0] stride_feature_width, stride_feature_height;
   logic [7:0]    stride_kernel_sizeh, stride_kernel_sizew;
   logic          stride_has_bias, stride_has_relu;
   logic [FW-1:0] stride_wb_baseaddr;
   logic [DW-1:0] stride_wb_ch_offset;
   logic          inst_valid, tlast;
   logic          decoder_ready, fram_rd_en, kram_rd_en;
   logic [FW-1:0] fram_rd_addr, wb_addr;
   logic [KW-1:0] kram_rd_addr;
   logic          mac_valid, mac_first, mac_bias, mac_last, mac_relu, layer_done;

   int    checks = 0;
   int    failures = 0;
   inst_t seq_q[$];
   cyc_t  exp_q[$];

   always #5 clk = ~clk;

   conv_stride_decoder #(
      .FADDR_W (FW),
      .KADDR_W (KW),
      .DATA_W  (DW)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .stride_feature_baseaddr (stride_feature_baseaddr),
      .stride_kernel_baseaddr  (stride_kernel_baseaddr),
      .stride_feature_chin     (stride_feature_chin),
      .stride_feature_chout    (stride_feature_chout),
      .stride_feature_width    (stride_feature_width),
      .stride_feature_height   (stride_feature_height),
      .stride_kernel_sizeh     (stride_kernel_sizeh),
      .stride_kernel_sizew     (stride_kernel_sizew),
      .stride_has_bias         (stride_has_bias),
      .stride_has_relu         (stride_has_relu),
      .stride_wb_baseaddr      (stride_wb_baseaddr),
      .stride_wb_ch_offset     (stride_wb_ch_offset),
      .inst_valid              (inst_valid),
      .tlast                   (tlast),
      .decoder_ready           (decoder_ready),
      .fram_rd_en              (fram_rd_en),
      .fram_rd_addr            (fram_rd_addr),
      .kram_rd_en              (kram_rd_en),
      .kram_rd_addr            (kram_rd_addr),
      .mac_valid               (mac_valid),
      .mac_first               (mac_first),
      .mac_bias                (mac_bias),
      .mac_last                (mac_last),
      .mac_relu                (mac_relu),
      .wb_addr                 (wb_addr),
      .layer_done              (layer_done)
   );

   task automatic drive(input inst_t s);
      stride_feature_baseaddr = FW'(s.fbase);
      stride_kernel_baseaddr  = KW'(s.kbase);
      stride_feature_chin     = DW'(s.chin);
      stride_feature_chout    = DW'(s.chout);
      stride_feature_width    = DW'(s.width);
      stride_feature_height   = DW'(s.height);
      stride_kernel_sizeh     = 8'(s.kh);
      stride_kernel_sizew     = 8'(s.kw);
      stride_has_bias         = s.bias;
      stride_has_relu         = s.relu;
      stride_wb_baseaddr      = FW'(s.wb_base);
      stride_wb_ch_offset     = DW'(s.wb_off);
      tlast                   = s.tlast;
   endtask

   // Reference: per instruction a setup cycle, then per output channel an optional
   // bias read, chin*kh*kw window reads and a drain cycle, then an idle cycle.
   task automatic build_expected();
      cyc_t        c;
      int unsigned k, wb;
      exp_q.delete();
      foreach (seq_q[i]) begin
         inst_t s = seq_q[i];
         k = s.kbase;
         c = '{default: 0};
         exp_q.push_back(c);
         if (s.chin != 0 && s.chout != 0 && s.kh != 0 && s.kw != 0) begin
            for (int unsigned co = 0; co < s.chout; co++) begin
               wb = (s.wb_base + co * s.wb_off) & FMASK;
               if (s.bias) begin
                  c = '{default: 0};
                  c.ken = 1; c.ka = k & KMASK; c.first = 1; c.bias = 1;
                  exp_q.push_back(c);
                  k++;
               end
               for (int unsigned ci = 0; ci < s.chin; ci++)
                  for (int unsigned r = 0; r < s.kh; r++)
                     for (int unsigned q = 0; q < s.kw; q++) begin
                        c = '{default: 0};
                        c.fen = 1; c.ken = 1;
                        c.fa  = (s.fbase + ci * (s.width * s.height) + r * s.width + q) & FMASK;
                        c.ka  = k & KMASK;
                        c.first = !s.bias && ci == 0 && r == 0 && q == 0;
                        c.last  = (ci == s.chin - 1) && (r == s.kh - 1) && (q == s.kw - 1);
                        c.relu  = c.last && s.relu;
                        c.wb    = c.last ? wb : 0;
                        exp_q.push_back(c);
                        k++;
                     end
               c = '{default: 0};
               exp_q.push_back(c);
            end
         end
         c = '{default: 0};
         c.ready = 1; c.done = s.tlast;
         exp_q.push_back(c);
      end
   endtask

   // Issues seq_q with inst_valid held high throughout, checking every cycle.
   task automatic run_seq(input string name);
      cyc_t          cur, prev;
      int unsigned   nxt;
      logic [FW-1:0] fa_act, wb_act;
      logic [KW-1:0] ka_act;
      build_expected();
      drive(seq_q[0]);
      inst_valid = 1'b1;
      nxt = 1;
      @(posedge clk);
      for (int t = 0; t < exp_q.size(); t++) begin
         @(negedge clk);
         if (t == 0 || exp_q[t-1].ready) begin
            if (nxt < seq_q.size()) begin
               drive(seq_q[nxt]);
               nxt++;
            end else begin
               inst_valid = 1'b0;
            end
         end
         cur  = exp_q[t];
         prev = (t == 0) ? '{default: 0} : exp_q[t-1];
         fa_act = fram_rd_en ? fram_rd_addr : '0;
         ka_act = kram_rd_en ? kram_rd_addr : '0;
         wb_act = mac_last ? wb_addr : '0;
         checks++;
         if ({fram_rd_en, fa_act, kram_rd_en, ka_act} !== {cur.fen, FW'(cur.fa), cur.ken, KW'(cur.ka)}) begin
            failures++;
            $display("FAIL %s rd cyc=%0d got fen=%b fa=%0d ken=%b ka=%0d want fen=%b fa=%0d ken=%b ka=%0d",
                     name, t, fram_rd_en, fa_act, kram_rd_en, ka_act, cur.fen, cur.fa, cur.ken, cur.ka);
         end
         checks++;
         if ({mac_valid, mac_first, mac_bias, mac_last, mac_last & mac_relu, wb_act} !==
             {prev.ken, prev.first, prev.bias, prev.last, prev.relu, FW'(prev.wb)}) begin
            failures++;
            $display("FAIL %s mac cyc=%0d got v=%b f=%b b=%b l=%b r=%b wb=%0d want v=%b f=%b b=%b l=%b r=%b wb=%0d",
                     name, t, mac_valid, mac_first, mac_bias, mac_last, mac_relu, wb_act,
                     prev.ken, prev.first, prev.bias, prev.last, prev.relu, prev.wb);
         end
         checks++;
         if ({decoder_ready, layer_done} !== {cur.ready, cur.done}) begin
            failures++;
            $display("FAIL %s ctrl cyc=%0d got ready=%b done=%b want ready=%b done=%b",
                     name, t, decoder_ready, layer_done, cur.ready, cur.done);
         end
      end
      inst_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if (decoder_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s ready got %b want 1", name, decoder_ready);
      end
      checks++;
      if ({fram_rd_en, fram_rd_addr, kram_rd_en, kram_rd_addr, mac_valid, mac_first, mac_bias,
           mac_last, mac_relu, wb_addr, layer_done} !== '0) begin
         failures++;
         $display("FAIL %s outputs not zero: fen=%b fa=%0d ken=%b ka=%0d v=%b l=%b wb=%0d done=%b",
                  name, fram_rd_en, fram_rd_addr, kram_rd_en, kram_rd_addr, mac_valid, mac_last,
                  wb_addr, layer_done);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      check_reset_outputs("reset");
   endtask

   task automatic test_basic();
      inst_t s = '{default: 0};
      s.fbase = 100; s.width = 8; s.height = 8; s.chin = 2; s.chout = 1; s.kh = 2; s.kw = 2;
      s.wb_base = 20; s.relu = 1;
      seq_q = {s};
      run_seq("basic");
   endtask

   task automatic test_bias();
      inst_t s = '{default: 0};
      s.fbase = 100; s.width = 8; s.height = 8; s.chin = 2; s.chout = 2; s.kh = 2; s.kw = 2;
      s.bias = 1; s.wb_base = 50; s.wb_off = 36; s.tlast = 1;
      seq_q = {s};
      run_seq("bias");
   endtask

   task automatic test_zero_dims();
      inst_t s = '{default: 0};
      s.fbase = 10; s.width = 4; s.height = 4; s.chin = 0; s.chout = 3; s.kh = 3; s.kw = 3;
      s.tlast = 1;
      seq_q = {s};
      run_seq("zero_dims");
   endtask

   task automatic test_back_to_back();
      inst_t a = '{default: 0};
      inst_t b;
      a.fbase = 200; a.kbase = 30; a.width = 5; a.height = 3; a.chin = 1; a.chout = 2;
      a.kh = 1; a.kw = 3; a.wb_base = 9; a.wb_off = 4;
      b = a;
      b.fbase = 700; b.kbase = 500; b.bias = 1; b.relu = 1; b.tlast = 1; b.chin = 2;
      seq_q = {a, b};
      run_seq("back_to_back");
   endtask

   task automatic test_reset_mid();
      inst_t s = '{default: 0};
      s.fbase = 300; s.kbase = 40; s.width = 10; s.height = 5; s.chin = 2; s.chout = 2;
      s.kh = 3; s.kw = 3; s.tlast = 1; s.wb_base = 7; s.wb_off = 3;
      drive(s);
      inst_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      inst_valid = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (fram_rd_en !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid issuing got fen=%b want 1", fram_rd_en);
      end
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("reset_mid");
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({decoder_ready, mac_valid, mac_last, layer_done, fram_rd_en, kram_rd_en} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_mid quiet cyc=%0d got rdy=%b v=%b l=%b done=%b fen=%b ken=%b",
                     i, decoder_ready, mac_valid, mac_last, layer_done, fram_rd_en, kram_rd_en);
         end
      end
      s.fbase = 1000; s.kbase = 800; s.chout = 1; s.bias = 1;
      seq_q = {s};
      run_seq("reset_restart");
   endtask

   task automatic test_addr_wrap();
      inst_t s = '{default: 0};
      s.fbase = (1 << FW) - 2; s.width = 4; s.height = 1; s.chin = 1; s.chout = 1;
      s.kh = 1; s.kw = 4; s.kbase = (1 << KW) - 1;
      seq_q = {s};
      run_seq("addr_wrap");
   endtask

   task automatic test_random();
      for (int it = 0; it < 16; it++) begin
         int n = $urandom_range(1, 3);
         seq_q.delete();
         for (int j = 0; j < n; j++) begin
            inst_t s;
            s.fbase   = $urandom_range(0, FMASK);
            s.kbase   = $urandom_range(0, KMASK);
            s.width   = $urandom_range(1, 40);
            s.height  = $urandom_range(1, 12);
            s.chin    = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            s.chout   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            s.kh      = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            s.kw      = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            s.wb_base = $urandom_range(0, FMASK);
            s.wb_off  = $urandom_range(0, 5000);
            s.bias    = $urandom_range(0, 1);
            s.relu    = $urandom_range(0, 1);
            s.tlast   = $urandom_range(0, 1);
            seq_q.push_back(s);
         end
         run_seq($sformatf("random%0d", it));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      inst_t z = '{default: 0};
      rst = 1'b1;
      inst_valid = 1'b0;
      drive(z);
      repeat (2) @(posedge clk);
      test_reset();
      rst = 1'b0;
      test_basic();
      test_bias();
      test_zero_dims();
      test_back_to_back();
      test_reset_mid();
      test_addr_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv_stride_decoder.md
Name: conv_stride_decoder

Overview:
- Consumer end of the stride-instruction interface: accepts one stride instruction per valid/ready handshake, carrying feature/kernel base, channel counts, kernel size, bias/relu flags, writeback base and channel offset, plus tlast.
- Expands each instruction into a cycle-by-cycle read stream to the feature BRAM and kernel BRAM.
- Drives MAC control (first/valid/last/bias/relu) aligned with BRAM read data, and issues one writeback address per output channel.
- Sits between the instruction generator and the MAC array/writeback path.

Parameters:
- FADDR_W, `FRAM_ADDR_WIDTH: feature BRAM word-address width
- KADDR_W, `KRAM_ADDR_WIDTH: kernel BRAM word-address width
- DATA_W, 32: width of dimension/count fields

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stride_feature_baseaddr  in  FADDR_W  feature window origin
- stride_kernel_baseaddr  in  KADDR_W  kernel block base
- stride_feature_chin  in  DATA_W  input channels
- stride_feature_chout  in  DATA_W  output channels
- stride_feature_width  in  DATA_W  feature row pitch
- stride_feature_height  in  DATA_W  feature rows
- stride_kernel_sizeh  in  8  kernel rows
- stride_kernel_sizew  in  8  kernel cols
- stride_has_bias  in  1  bias word precedes each output channel's weights
- stride_has_relu  in  1  ReLU flag, forwarded
- stride_wb_baseaddr  in  FADDR_W  writeback address of output channel 0
- stride_wb_ch_offset  in  DATA_W  writeback stride between output channels
- inst_valid  in  1  instruction valid
- tlast  in  1  last instruction of a layer
- decoder_ready  out  1  high only in IDLE
- fram_rd_en  out  1  feature BRAM read enable
- fram_rd_addr  out  FADDR_W  feature BRAM read address
- kram_rd_en  out  1  kernel BRAM read enable
- kram_rd_addr  out  KADDR_W  kernel BRAM read address
- mac_valid  out  1  operand pair valid on BRAM data (rd_en delayed 1 cycle)
- mac_first  out  1  first operand of an output channel; MAC clears accumulator
- mac_bias  out  1  kernel data is a bias word (no feature operand)
- mac_last  out  1  final operand of an output channel
- mac_relu  out  1  latched has_relu, valid with mac_last
- wb_addr  out  FADDR_W  writeback address, valid with mac_last
- layer_done  out  1  one-cycle pulse after the last channel of a tlast instruction

Behaviour:
- Reset: all outputs 0 except decoder_ready=1; state IDLE; all counters 0.
- Handshake: accept when inst_valid && decoder_ready. On accept, latch all fields and tlast; compute ch_off = width*height, truncated to FADDR_W. Go to SETUP.
- SETUP (1 cycle):
  - If chin, chout, kh or kw is 0, return to IDLE; no reads; layer_done pulses if tlast was latched.
  - Otherwise go to BIAS if has_bias, else ISSUE.
- BIAS (1 cycle): kram_rd_en=1, fram_rd_en=0, at the running kernel address, which then increments. Tag first=1, bias=1.
- ISSUE: one feature + kernel read per cycle, loop order kw (inner), kh, ci, then co (outer).
  - Kernel address: linear running counter from kbase, incremented every kernel read, including bias reads.
  - Feature address: col_ptr increments by 1.
  - On kw wrap: col_ptr = row_ptr + width, and row_ptr advances likewise.
  - On kh wrap: ch_ptr += ch_off; row_ptr = col_ptr = ch_ptr.
  - On ci wrap: all pointers reload fbase.
  - The first ISSUE read of a channel without bias carries first=1. The final read of a channel carries last=1.
- DRAIN (1 cycle) after each channel's last read: no reads.
  - wb_ptr += wb_ch_offset. wb_ptr starts at wb_base on accept.
  - Next state: BIAS/ISSUE if co < chout-1, else IDLE.
- Pipeline: tags (first/bias/last) are registered 1 cycle and appear as mac_* together with BRAM data. wb_addr = wb_ptr is registered alongside mac_last.
- Channel cost: (has_bias) + chin*kh*kw + 1 cycles per output channel.
- layer_done: 1 cycle after the mac_last of the final channel, only when tlast was latched. decoder_ready rises in that same cycle.
- Address arithmetic: modulo 2^ADDR_W, wraps silently.
- No downstream backpressure. inst_valid while busy is ignored.
- rst mid-operation: aborts immediately to reset values. No mac_last or layer_done is emitted for the aborted instruction.

Decomposition:
- Shared package conv_pkg holds:
  - state enum {IDLE, SETUP, BIAS, ISSUE, DRAIN}
  - a packed stride_inst_t struct of all instruction fields
  - the BRAM read-latency constant (1)
- One natural sub-module, conv_addr_walker: the nested kw/kh/ci counters and feature pointers, with step/wrap outputs. The FSM, kernel counter and output tags stay in the top.

Test Plan:
- Instruction fbase=100, width=8, height=8, chin=2, chout=1, kh=kw=2, no bias, kbase=0:
  - fram_rd_addr = 100,101,108,109,164,165,172,173; kram_rd_addr = 0..7 on consecutive cycles.
  - mac_first on the 1st operand, mac_last on the 8th; ready returns after DRAIN.
- Same with has_bias=1, chout=2, wb_base=50, wb_ch_offset=36:
  - kram_rd_addr = 0(bias),1..8, then 9(bias),10..17.
  - wb_addr = 50 then 86 with each mac_last; mac_bias high only on words 0 and 9.
- chin=0 with tlast=1: no rd_en ever asserted; layer_done pulses once; decoder_ready back after 2 cycles.
- Back-to-back instructions, inst_valid held high with the second carrying tlast: second accepted exactly in the cycle ready reasserts; layer_done only after the second's final mac_last.
- Assert rst during ISSUE of a 3x3 kernel: next cycle all outputs 0 and ready=1; a new instruction afterwards produces correct addresses from its own base.
- fbase = 2^FADDR_W-2, width=4, kh=1, kw=4: fram_rd_addr wraps to 0,1 after max-1, max.
